// File: rtl/noc_pci_gather_pkg.sv
// Shared NoC/PCIe geometry for the gather (return) path and the scatter side.
// Also holds the header field offsets inside a flit.
package noc_pci_gather_pkg;

  localparam int NPG_DATA_W  = 32;
  localparam int NPG_X_W     = 2;
  localparam int NPG_Y_W     = 2;
  localparam int NPG_TOTAL_W = NPG_DATA_W + NPG_X_W + NPG_Y_W;
  localparam int NPG_PCI_W   = 256;
  localparam int NPG_LANES   = NPG_PCI_W / NPG_DATA_W;

  // Header sits directly above the payload: x first, then y.
  localparam int NPG_HDR_X_LSB = NPG_DATA_W;
  localparam int NPG_HDR_Y_LSB = NPG_DATA_W + NPG_X_W;

  function automatic int npg_fill_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/noc_pci_gather_lane_asm.sv
// Assembly register: lane array, fill counter and lane write decode.
// Exposes a look-ahead view that already includes this cycle's write.
module gather_lane_asm
  import noc_pci_gather_pkg::*;
#(
  parameter int DATA_W = NPG_DATA_W,
  parameter int LANES  = NPG_LANES,
  parameter int FILL_W = npg_fill_width(NPG_LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     clr_i,
  output logic [LANES*DATA_W-1:0]  word_nxt_o,
  output logic [FILL_W-1:0]        fill_o,
  output logic [FILL_W-1:0]        fill_nxt_o,
  output logic                     full_o
);

  logic [DATA_W-1:0] lanes_q [LANES];
  logic [DATA_W-1:0] lanes_d [LANES];
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lanes_d[k] = lanes_q[k];
      if (wr_en_i && (fill_q == FILL_W'(k))) begin
        lanes_d[k] = wr_data_i;
      end
    end
    fill_d = fill_q + FILL_W'(wr_en_i);
  end

  always_comb begin
    word_nxt_o = '0;
    for (int k = 0; k < LANES; k++) begin
      word_nxt_o[DATA_W*k +: DATA_W] = lanes_d[k];
    end
  end

  assign fill_o     = fill_q;
  assign fill_nxt_o = fill_d;
  assign full_o     = (fill_q == FILL_W'(LANES));

  // Clearing lanes on transfer keeps unused lanes of the next beat at zero.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      fill_q <= '0;
      for (int k = 0; k < LANES; k++) begin
        lanes_q[k] <= '0;
      end
    end else begin
      fill_q <= fill_d;
      for (int k = 0; k < LANES; k++) begin
        lanes_q[k] <= lanes_d[k];
      end
    end
  end

endmodule

// File: rtl/noc_pci_gather.sv
// Gathers mesh result flits at node (0,0) into 256-bit PCIe beats.
// Assembly register plus output register give one beat of slack against PCIe backpressure.
module noc_pci_gather
  import noc_pci_gather_pkg::*;
#(
  parameter int DATA_W  = NPG_DATA_W,
  parameter int X_W     = NPG_X_W,
  parameter int Y_W     = NPG_Y_W,
  parameter int TOTAL_W = DATA_W + X_W + Y_W,
  parameter int LANES   = NPG_PCI_W / DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [TOTAL_W-1:0]      i_data,
  output logic                    o_ready,
  input  logic                    i_flush,
  output logic [NPG_PCI_W-1:0]    o_data_pci,
  output logic [LANES-1:0]        o_keep_pci,
  output logic                    o_valid_pci,
  input  logic                    i_ready_pci
);

  localparam int PCI_W  = NPG_PCI_W;
  localparam int FILL_W = npg_fill_width(LANES);
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic              accept;
  logic              drain;
  logic              out_free;
  logic              tmo_hit;
  logic              soft_close;
  logic              close;
  logic              transfer;
  logic              full;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic [PCI_W-1:0]  word_nxt;
  logic [LANES-1:0]  keep_nxt;

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              flush_pend_q, flush_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [PCI_W-1:0]  out_data_q, out_data_d;
  logic [LANES-1:0]  out_keep_q, out_keep_d;

  // Routing header is not needed past the exit node.
  logic unused_hdr;
  assign unused_hdr = ^i_data[TOTAL_W-1:DATA_W];

  gather_lane_asm #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .FILL_W (FILL_W)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (accept),
    .wr_data_i  (i_data[DATA_W-1:0]),
    .clr_i      (transfer),
    .word_nxt_o (word_nxt),
    .fill_o     (fill),
    .fill_nxt_o (fill_nxt),
    .full_o     (full)
  );

  // Handshakes: a flit moves when i_valid && o_ready; a beat moves when
  // o_valid_pci && i_ready_pci. Beat contents are frozen while it waits.
  assign o_ready  = !full;
  assign accept   = i_valid && !full;
  assign drain    = out_valid_q && i_ready_pci;
  assign out_free = !out_valid_q || drain;

  assign tmo_hit    = (TIMEOUT != 0) && (idle_q == IDLE_W'(TIMEOUT)) && (fill != '0);
  assign soft_close = (i_flush && (fill_nxt != '0)) || tmo_hit;
  assign close      = (fill_nxt == FILL_W'(LANES)) || soft_close || flush_pend_q;
  assign transfer   = close && out_free && (fill_nxt != '0);

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      keep_nxt[k] = (FILL_W'(k) < fill_nxt);
    end
  end

  always_comb begin
    idle_d       = idle_q;
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;

    if (accept || transfer) begin
      idle_d = '0;
    end else if ((fill != '0) && !flush_pend_q && (idle_q != IDLE_W'(TIMEOUT))) begin
      idle_d = idle_q + 1'b1;
    end

    // A blocked flush/timeout close waits here until the output frees up.
    if (transfer) begin
      flush_pend_d = 1'b0;
    end else if (soft_close) begin
      flush_pend_d = 1'b1;
    end

    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = word_nxt;
      out_keep_d  = keep_nxt;
    end else if (drain) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_keep_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q       <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
    end else begin
      idle_q       <= idle_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
    end
  end

  assign o_valid_pci = out_valid_q;
  assign o_data_pci  = out_data_q;
  assign o_keep_pci  = out_keep_q;

endmodule

// File: tb/tb_noc_pci_gather.sv
// Bench for noc_pci_gather: directed scenarios plus random traffic against a
// queue-based model of the assembly buffer and the single-beat output slot.
module tb_noc_pci_gather;

  localparam int DATA_W  = 32;
  localparam int X_W     = 2;
  localparam int Y_W     = 2;
  localparam int TOTAL_W = DATA_W + X_W + Y_W;
  localparam int LANES   = 256 / DATA_W;
  localparam int PCI_W   = 256;
  localparam int TIMEOUT = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic i_valid;
  logic [TOTAL_W-1:0] i_data;
  logic o_ready;
  logic i_flush;
  logic [PCI_W-1:0] o_data_pci;
  logic [LANES-1:0] o_keep_pci;
  logic o_valid_pci;
  logic i_ready_pci;

  always #5 clk = ~clk;

  noc_pci_gather #(
    .DATA_W  (DATA_W),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .TOTAL_W (TOTAL_W),
    .LANES   (LANES),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .i_flush     (i_flush),
    .o_data_pci  (o_data_pci),
    .o_keep_pci  (o_keep_pci),
    .o_valid_pci (o_valid_pci),
    .i_ready_pci (i_ready_pci)
  );

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0]      asm_q[$];   // words waiting in the assembly buffer
  logic [LANES+PCI_W-1:0] exp_q[$];   // {keep, data} of the beat in the output slot
  bit m_valid;
  bit m_pend;
  int m_idle;

  task automatic check(input string tag, input logic [PCI_W-1:0] got, input logic [PCI_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit v, input logic [DATA_W-1:0] pay, input bit fl, input bit rdy, input bit r);
    bit acc, drain, tmo, close, pend_old;
    int n, n_old;
    logic [PCI_W-1:0] beat;
    logic [LANES-1:0] keep;
    i_valid     = v;
    i_data      = {(X_W + Y_W)'($urandom_range(0, 15)), pay};
    i_flush     = fl;
    i_ready_pci = rdy;
    rst         = r;
    @(posedge clk);
    if (r) begin
      asm_q.delete();
      exp_q.delete();
      m_valid = 0;
      m_pend  = 0;
      m_idle  = 0;
    end else begin
      n_old    = asm_q.size();
      pend_old = m_pend;
      acc      = v && (n_old < LANES);
      if (acc) asm_q.push_back(pay);
      n     = asm_q.size();
      drain = m_valid && rdy;
      if (drain) begin
        void'(exp_q.pop_front());
        m_valid = 0;
      end
      tmo   = (TIMEOUT > 0) && (m_idle == TIMEOUT) && (n_old > 0);
      close = (n == LANES) || (fl && n > 0) || tmo || m_pend;
      if (close && !m_valid && n > 0) begin
        beat = '0;
        keep = '0;
        for (int k = 0; k < n; k++) begin
          beat[k*DATA_W +: DATA_W] = asm_q[k];
          keep[k] = 1'b1;
        end
        exp_q.push_back({keep, beat});
        asm_q.delete();
        m_valid = 1;
        m_pend  = 0;
        m_idle  = 0;
      end else begin
        if ((fl && n > 0) || tmo) m_pend = 1;
        if (acc) m_idle = 0;
        else if (n_old > 0 && !pend_old && m_idle < TIMEOUT) m_idle++;
      end
    end
    #1;
    check("o_ready", o_ready, asm_q.size() < LANES);
    check("o_valid_pci", o_valid_pci, m_valid);
    if (m_valid && exp_q.size() > 0) begin
      check("o_data_pci", o_data_pci, exp_q[0][PCI_W-1:0]);
      check("o_keep_pci", o_keep_pci, exp_q[0][PCI_W +: LANES]);
    end
  endtask

  task automatic idle_cycles(input int cnt, input bit rdy);
    for (int i = 0; i < cnt; i++) step(0, '0, 0, rdy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first;
    int vprob;
    rst = 1'b1; i_valid = 0; i_data = '0; i_flush = 0; i_ready_pci = 0;

    // Reset state
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    check("rst_data", o_data_pci, '0);
    check("rst_keep", o_keep_pci, '0);
    check("rst_ready", o_ready, 1'b1);

    // Full beat 0x11..0x88
    for (int k = 1; k <= 8; k++) step(1, DATA_W'(32'h11 * k), 0, 1, 0);
    check("fb_lane0", o_data_pci[31:0], 32'h11);
    check("fb_lane7", o_data_pci[255:224], 32'h88);
    check("fb_keep", o_keep_pci, 8'hFF);
    idle_cycles(2, 1);

    // Backpressure: 16 flits with the sink stalled
    for (int k = 1; k <= 16; k++) step(1, DATA_W'(k), 0, 0, 0);
    check("bp_ready_low", o_ready, 1'b0);
    for (int k = 0; k < 4; k++) step(1, 32'hDEAD_0000 + DATA_W'(k), 0, 0, 0);
    step(0, '0, 0, 1, 0);
    check("bp_second_lane0", o_data_pci[31:0], 32'h9);
    idle_cycles(3, 1);

    // Timeout: 3 flits then idle
    for (int k = 1; k <= 3; k++) step(1, DATA_W'(32'hA0 + k), 0, 1, 0);
    first = 0;
    for (int k = 1; k <= TIMEOUT + 16 && first == 0; k++) begin
      step(0, '0, 0, 1, 0);
      if (o_valid_pci) begin
        first = k;
        check("tmo_keep", o_keep_pci, 8'h07);
      end
    end
    check("tmo_latency", first, TIMEOUT + 1);
    idle_cycles(2, 1);

    // Flush together with the 5th accept, then a flush on an empty buffer
    for (int k = 1; k <= 4; k++) step(1, DATA_W'(32'hB0 + k), 0, 1, 0);
    step(1, 32'hB5, 1, 1, 0);
    check("fl_keep", o_keep_pci, 8'h1F);
    idle_cycles(2, 1);
    step(0, '0, 1, 1, 0);
    step(0, '0, 0, 1, 0);
    check("fl_empty_novalid", o_valid_pci, 1'b0);

    // Flush while the output register is blocked
    for (int k = 1; k <= 8; k++) step(1, DATA_W'(32'hC0 + k), 0, 0, 0);
    step(1, 32'hD1, 0, 0, 0);
    step(1, 32'hD2, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    idle_cycles(3, 0);
    step(1, 32'hD3, 0, 0, 0);
    idle_cycles(2, 0);
    step(0, '0, 0, 1, 0);
    check("flb_keep", o_keep_pci, 8'h07);
    idle_cycles(2, 1);

    // Reset mid-operation
    for (int k = 1; k <= 8; k++) step(1, DATA_W'(32'hE0 + k), 0, 0, 0);
    for (int k = 1; k <= 5; k++) step(1, DATA_W'(32'hE8 + k), 0, 0, 0);
    step(0, '0, 0, 0, 1);
    check("rm_valid", o_valid_pci, 1'b0);
    check("rm_ready", o_ready, 1'b1);
    for (int k = 1; k <= 8; k++) step(1, DATA_W'(32'hF0 + k), 0, 1, 0);
    check("rm_keep", o_keep_pci, 8'hFF);
    idle_cycles(2, 1);

    // Random traffic with varying flit density and backpressure
    for (int blk = 0; blk < 16; blk++) begin
      vprob = $urandom_range(2, 100);
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(1, 100) <= vprob, DATA_W'($urandom),
             $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7,
             $urandom_range(0, 599) == 0);
      end
    end
    idle_cycles(TIMEOUT + 8, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
